// File: rtl/quad_encoder_pair_pkg.sv
// Shared encodings for the quadrature generator/decoder pair: direction codes
// and the Gray step tables that both sides agree on.
package quad_encoder_pair_pkg;

    localparam logic [1:0] DIR_IDLE = 2'b00;
    localparam logic [1:0] DIR_CW   = 2'b01;
    localparam logic [1:0] DIR_CCW  = 2'b10;
    localparam logic [1:0] DIR_ERR  = 2'b11;

    // State value is the {A,B} pair itself, so outputs come straight off the flops.
    typedef enum logic [1:0] {
        AB_00 = 2'b00,
        AB_10 = 2'b10,
        AB_11 = 2'b11,
        AB_01 = 2'b01
    } ab_state_t;

    function automatic logic [1:0] next_cw(input logic [1:0] ab);
        logic [1:0] r;
        case (ab)
            2'b00:   r = 2'b10;
            2'b10:   r = 2'b11;
            2'b11:   r = 2'b01;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] next_ccw(input logic [1:0] ab);
        logic [1:0] r;
        case (ab)
            2'b00:   r = 2'b01;
            2'b01:   r = 2'b11;
            2'b11:   r = 2'b10;
            default: r = 2'b00;
        endcase
        return r;
    endfunction

    function automatic logic [1:0] decode_dir(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] r;
        if (cur == prev)                r = DIR_IDLE;
        else if (cur == next_cw(prev))  r = DIR_CW;
        else if (cur == next_ccw(prev)) r = DIR_CCW;
        else                            r = DIR_ERR;
        return r;
    endfunction

endpackage

// File: rtl/quad_encoder_pair_if.sv
// Step-request / quadrature / direction bundle between the block and its user.
interface quad_encoder_pair_if;
    logic       horario;
    logic       antihorario;
    logic       A;
    logic       B;
    logic [1:0] dir;

    modport master (output horario, output antihorario, input A, input B, input dir);
    modport slave  (input horario, input antihorario, output A, output B, output dir);
endinterface

// File: rtl/quad_encoder_pair_encoder.sv
// Quadrature generator: one Gray step per clock in the requested direction;
// simultaneous or absent requests hold the position.
module quad_encoder_pair_encoder
    import quad_encoder_pair_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic horario,
    input  logic antihorario,
    output logic A,
    output logic B
);

    ab_state_t state, state_nxt;

    // rst_n is active-high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state <= AB_00;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case ({horario, antihorario})
            2'b10:   state_nxt = ab_state_t'(next_cw(state));
            2'b01:   state_nxt = ab_state_t'(next_ccw(state));
            default: state_nxt = state;
        endcase
    end

    assign {A, B} = state;

endmodule

// File: rtl/quad_encoder_pair_reader.sv
// Quadrature decoder: compares the registered previous {A,B} with the live
// pair, so a step is reported during the cycle right after it happens.
module quad_encoder_pair_reader
    import quad_encoder_pair_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       A,
    input  logic       B,
    output logic [1:0] dir
);

    logic [1:0] prev;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) prev <= 2'b00;
        else       prev <= {A, B};
    end

    assign dir = decode_dir(prev, {A, B});

endmodule

// File: rtl/quad_encoder_pair.sv
// Encoder/decoder loopback: the generated A/B pair feeds the direction decoder.
module quad_encoder_pair
    import quad_encoder_pair_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    quad_encoder_pair_if.slave   bus
);

    logic enc_a, enc_b;

    quad_encoder_pair_encoder u_encoder (
        .clk         (clk),
        .rst_n       (rst_n),
        .horario     (bus.horario),
        .antihorario (bus.antihorario),
        .A           (enc_a),
        .B           (enc_b)
    );

    quad_encoder_pair_reader u_reader (
        .clk   (clk),
        .rst_n (rst_n),
        .A     (enc_a),
        .B     (enc_b),
        .dir   (bus.dir)
    );

    assign bus.A = enc_a;
    assign bus.B = enc_b;

endmodule

// File: tb/tb_quad_encoder_pair.sv
// Bench for quad_encoder_pair: directed vector table, random requests against
// a position-based model, mid-cycle reset, and a stand-alone decoder check.
module tb_quad_encoder_pair;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    quad_encoder_pair_if bus ();

    quad_encoder_pair dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Decoder on its own, to reach a two-bit jump the encoder never produces.
    logic       dec_rst = 1'b1;
    logic       dec_a = 1'b0, dec_b = 1'b0;
    logic [1:0] dec_dir;

    quad_encoder_pair_reader u_dec (
        .clk   (clk),
        .rst_n (dec_rst),
        .A     (dec_a),
        .B     (dec_b),
        .dir   (dec_dir)
    );

    int errors = 0;
    int checks = 0;

    // Model: shaft position modulo 4, mapped to the Gray pair by a table.
    logic [1:0] gray [4];
    int         pos;
    logic [1:0] exp_dir;

    typedef struct {
        logic       h;
        logic       ac;
        logic [1:0] ab;
        logic [1:0] dir;
    } vec_t;

    vec_t vecs [14];

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic h, input logic ac);
        int d;
        d = (h && !ac) ? 1 : (!h && ac) ? -1 : 0;
        pos = (pos + d + 4) % 4;
        exp_dir = (d == 1) ? 2'b01 : (d == -1) ? 2'b10 : 2'b00;
    endtask

    // Called at a negedge: drive, let one rising edge pass, check at next negedge.
    task automatic step(input logic h, input logic ac);
        bus.horario = h;
        bus.antihorario = ac;
        @(posedge clk);
        model_step(h, ac);
        @(negedge clk);
    endtask

    initial begin
        gray[0] = 2'b00; gray[1] = 2'b10; gray[2] = 2'b11; gray[3] = 2'b01;
        pos = 0;
        exp_dir = 2'b00;
        bus.horario = 1'b0;
        bus.antihorario = 1'b0;

        // Spec sequence: idle x3, cw x5, ccw x4, both x2.
        for (int i = 0; i < 3; i++)  vecs[i]    = '{1'b0, 1'b0, 2'b00, 2'b00};
        vecs[3]  = '{1'b1, 1'b0, 2'b10, 2'b01};
        vecs[4]  = '{1'b1, 1'b0, 2'b11, 2'b01};
        vecs[5]  = '{1'b1, 1'b0, 2'b01, 2'b01};
        vecs[6]  = '{1'b1, 1'b0, 2'b00, 2'b01};
        vecs[7]  = '{1'b1, 1'b0, 2'b10, 2'b01};
        vecs[8]  = '{1'b0, 1'b1, 2'b00, 2'b10};
        vecs[9]  = '{1'b0, 1'b1, 2'b01, 2'b10};
        vecs[10] = '{1'b0, 1'b1, 2'b11, 2'b10};
        vecs[11] = '{1'b0, 1'b1, 2'b10, 2'b10};
        vecs[12] = '{1'b1, 1'b1, 2'b10, 2'b00};
        vecs[13] = '{1'b1, 1'b1, 2'b10, 2'b00};

        // Reset state, held across edges.
        repeat (2) @(negedge clk);
        check("reset_ab", {bus.A, bus.B}, 2'b00);
        check("reset_dir", bus.dir, 2'b00);
        rst_n = 1'b0;
        dec_rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].h, vecs[i].ac);
            check($sformatf("vec%0d_ab", i), {bus.A, bus.B}, vecs[i].ab);
            check($sformatf("vec%0d_dir", i), bus.dir, vecs[i].dir);
        end
        // Table leaves the shaft at position 1 ({A,B}=10).
        pos = 1;

        step(1'b0, 1'b0);
        check("release_dir", bus.dir, 2'b00);

        // Two steps then reset asserted mid-cycle.
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        #2 rst_n = 1'b1;
        #1;
        check("midrst_ab", {bus.A, bus.B}, 2'b00);
        check("midrst_dir", bus.dir, 2'b00);
        @(negedge clk);
        check("midrst_hold_ab", {bus.A, bus.B}, 2'b00);
        rst_n = 1'b0;
        pos = 0;
        step(1'b1, 1'b0);
        check("post_rst_ab", {bus.A, bus.B}, 2'b10);
        check("post_rst_dir", bus.dir, 2'b01);

        // Random requests against the model.
        for (int i = 0; i < 200; i++) begin
            int r;
            r = $urandom_range(0, 3);
            step(r[1], r[0]);
            check("rand_ab", {bus.A, bus.B}, gray[pos]);
            check("rand_dir", bus.dir, exp_dir);
        end

        // Decoder: 00 -> 11 in a single edge reports illegal for one cycle.
        check("dec_idle", dec_dir, 2'b00);
        @(posedge clk);
        #1 {dec_a, dec_b} = 2'b11;
        @(negedge clk);
        check("dec_err", dec_dir, 2'b11);
        @(negedge clk);
        check("dec_err_clear", dec_dir, 2'b00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
